alu_share_arbiter: RTL

Sequencer/arbiter that shares the single 32-bit ALU between two requesters (requester 0: main datapath sequencer; requester 1: address/auxiliary unit). It accepts level-held requests, grants one at a time with round-robin priority, drives the ALU operand and opcode inputs from registered copies, captures the ALU result and zero flag, and returns them with a one-cycle acknowledge. It sits between the requesters and the combinational ALU instance.

---
 rtl/alu_share_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational 32-bit ALU between two requesters using round-robin arbitration.
// Each operation takes IDLE -> EXEC -> DONE and ends with a one-cycle acknowledge.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] op1_0,
  input  logic [DATA_W-1:0] op2_0,
  input  logic [OP_W-1:0]   aluop_0,
  input  logic [DATA_W-1:0] op1_1,
  input  logic [DATA_W-1:0] op2_1,
  input  logic [OP_W-1:0]   aluop_1,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              gnt_q, gnt_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [OP_W-1:0]   opc_q, opc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1101: op_supported = 1'b1;
      default:                            op_supported = 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every next-state signal is given its hold value first, so no path can infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    opc_d    = opc_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Under contention the pointer decides; otherwise the lone requester wins.
          gnt_d   = (req0 && req1) ? ptr_q : req1;
          op1_d   = gnt_d ? op1_1   : op1_0;
          op2_d   = gnt_d ? op2_1   : op2_0;
          opc_d   = gnt_d ? aluop_1 : aluop_0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op_supported(opc_q)) begin
          result_d = alu_result;
          zero_d   = alu_zero;
        end else begin
          result_d = '0;
          zero_d   = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register, including the operand and result copies, is cleared by reset
  // because the outputs must read 0 while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      opc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      opc_q    <= opc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign alu_op1 = op1_q;
  assign alu_op2 = op2_q;
  assign alu_op  = opc_q;
  assign ack0    = (state_q == DONE) && !gnt_q;
  assign ack1    = (state_q == DONE) &&  gnt_q;
  assign err     = (state_q == DONE) && !op_supported(opc_q);
  assign result  = result_q;
  assign zero    = zero_q;
  assign busy    = (state_q != IDLE);

endmodule
